// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle RV32I control sequencer for the ALU datapath.
// Accepts one instruction per handshake, walks it through
// DECODE/EXEC/MEM/WB and drives the ALU op, operand select,
// immediate and datapath strobes.
module alu_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic [3:0]  alu_op,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        pc_write,
    output logic        branch_taken,
    output logic        done,
    output logic        illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] instr_reg;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        dec_r, dec_i, dec_lw, dec_sw, dec_beq, dec_legal;
    logic [3:0]  dec_alu_op;
    logic        dec_src_imm;

    // The rs1 field never influences control; fold it away explicitly.
    logic        unused_rs1;
    assign unused_rs1 = ^instr_reg[19:15];

    assign opcode = instr_reg[6:0];
    assign funct3 = instr_reg[14:12];
    assign funct7 = instr_reg[31:25];

    // Instruction class decode of the latched word.
    always_comb begin
        dec_r   = (opcode == OP_R) &&
                  (((funct3 == 3'b000) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
                   ((funct3 == 3'b110) && (funct7 == 7'b0000000)) ||
                   ((funct3 == 3'b111) && (funct7 == 7'b0000000)));
        dec_i   = (opcode == OP_I) &&
                  ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111));
        dec_lw  = (opcode == OP_LW)  && (funct3 == 3'b010);
        dec_sw  = (opcode == OP_SW)  && (funct3 == 3'b010);
        dec_beq = (opcode == OP_BEQ) && (funct3 == 3'b000);
        dec_legal   = dec_r | dec_i | dec_lw | dec_sw | dec_beq;
        dec_src_imm = dec_i | dec_lw | dec_sw;
    end

    // ALU operation for the latched instruction; beq compares by subtracting.
    always_comb begin
        dec_alu_op = ALU_ADD;
        if (dec_beq || (dec_r && (funct3 == 3'b000) && funct7[5])) begin
            dec_alu_op = ALU_SUB;
        end else if ((dec_r || dec_i) && (funct3 == 3'b110)) begin
            dec_alu_op = ALU_OR;
        end else if ((dec_r || dec_i) && (funct3 == 3'b111)) begin
            dec_alu_op = ALU_AND;
        end
    end

    // Sign-extended immediate selected by instruction format.
    always_comb begin
        imm = 32'd0;
        case (opcode)
            OP_I, OP_LW: imm = {{20{instr_reg[31]}}, instr_reg[31:20]};
            OP_SW:       imm = {{20{instr_reg[31]}}, instr_reg[31:25], instr_reg[11:7]};
            OP_BEQ:      imm = {{19{instr_reg[31]}}, instr_reg[31], instr_reg[7],
                                instr_reg[30:25], instr_reg[11:8], 1'b0};
            default:     imm = 32'd0;
        endcase
    end

    // State register and instruction latch; the latch loads only on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            instr_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == S_IDLE) && instr_valid) begin
                instr_reg <= instr;
            end
        end
    end

    // Next-state and output decode; ALU controls persist from EXEC to retirement.
    always_comb begin
        state_next   = state_reg;
        instr_ready  = 1'b0;
        alu_op       = ALU_AND;
        alu_src_imm  = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        pc_write     = 1'b0;
        branch_taken = 1'b0;
        done         = 1'b0;
        illegal      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    done       = 1'b1;
                    illegal    = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op      = dec_alu_op;
                alu_src_imm = dec_src_imm;
                if (dec_beq) begin
                    branch_taken = alu_zero;
                    pc_write     = 1'b1;
                    done         = 1'b1;
                    state_next   = S_IDLE;
                end else if (dec_lw || dec_sw) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                alu_op      = dec_alu_op;
                alu_src_imm = dec_src_imm;
                mem_read    = dec_lw;
                mem_write   = dec_sw;
                if (mem_ready) begin
                    if (dec_sw) begin
                        pc_write   = 1'b1;
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                alu_op      = dec_alu_op;
                alu_src_imm = dec_src_imm;
                reg_write   = 1'b1;
                mem_to_reg  = dec_lw;
                pc_write    = 1'b1;
                done        = 1'b1;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vectors against a cycle-timeline model of
// the sequencer, plus literal latency/immediate expectations.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_zero;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic [31:0] imm;
    logic        mem_read, mem_write, mem_to_reg, reg_write;
    logic        pc_write, branch_taken, done, illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .alu_zero     (alu_zero),
        .mem_ready    (mem_ready),
        .alu_op       (alu_op),
        .alu_src_imm  (alu_src_imm),
        .imm          (imm),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_to_reg   (mem_to_reg),
        .reg_write    (reg_write),
        .pc_write     (pc_write),
        .branch_taken (branch_taken),
        .done         (done),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [2:0] C_ILL = 3'd0, C_R = 3'd1, C_I = 3'd2, C_LW = 3'd3, C_SW = 3'd4, C_BEQ = 3'd5;

    typedef struct packed {
        logic [2:0]  cls;
        logic [3:0]  op;
        logic        src;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t        d;
        logic [16:0] key;
        d   = '0;
        key = {w[31:25], w[14:12], w[6:0]};
        casez (key)
            17'b0000000_000_0110011: begin d.cls = C_R;   d.op = 4'b0010; end
            17'b0100000_000_0110011: begin d.cls = C_R;   d.op = 4'b0110; end
            17'b0000000_110_0110011: begin d.cls = C_R;   d.op = 4'b0001; end
            17'b0000000_111_0110011: begin d.cls = C_R;   d.op = 4'b0000; end
            17'b???????_000_0010011: begin d.cls = C_I;   d.op = 4'b0010; d.src = 1'b1; end
            17'b???????_110_0010011: begin d.cls = C_I;   d.op = 4'b0001; d.src = 1'b1; end
            17'b???????_111_0010011: begin d.cls = C_I;   d.op = 4'b0000; d.src = 1'b1; end
            17'b???????_010_0000011: begin d.cls = C_LW;  d.op = 4'b0010; d.src = 1'b1; end
            17'b???????_010_0100011: begin d.cls = C_SW;  d.op = 4'b0010; d.src = 1'b1; end
            17'b???????_000_1100011: begin d.cls = C_BEQ; d.op = 4'b0110; end
            default:                 d.cls = C_ILL;
        endcase
        case (d.cls)
            C_I, C_LW: d.imm = {{20{w[31]}}, w[31:20]};
            C_SW:      d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
            C_BEQ:     d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default:   d.imm = 32'd0;
        endcase
        return d;
    endfunction

    // Model state: cycle offset since the handshake and memory-phase progress.
    logic [31:0] m_instr = 32'd0;
    bit          m_busy = 1'b0;
    bit          m_memdone = 1'b0;
    int          m_k = 0;

    // Per-cycle comparison of every output against the timeline model.
    always @(negedge clk) begin
        dec_t d;
        bit e_ready, e_src, e_mr, e_mw, e_m2r, e_rw, e_pc, e_bt, e_done, e_ill, chk_imm, fin;
        logic [3:0]  e_op;
        logic [31:0] e_imm;
        e_ready = 0; e_src = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_rw = 0;
        e_pc = 0; e_bt = 0; e_done = 0; e_ill = 0; chk_imm = 0; fin = 0;
        e_op = 4'b0000; e_imm = 32'd0;
        d = ref_decode(m_instr);
        if (!rst_n) begin
            e_ready = 1; chk_imm = 1; e_imm = 32'd0;
            m_busy = 0; m_instr = 32'd0;
        end else if (!m_busy) begin
            e_ready = 1;
            if (instr_valid) begin
                m_busy = 1; m_instr = instr; m_k = 1; m_memdone = 0;
            end
        end else begin
            if (m_k == 1) begin
                if (d.cls == C_ILL) begin e_done = 1; e_ill = 1; fin = 1; end
            end else begin
                e_op = d.op; e_src = d.src; e_imm = d.imm; chk_imm = 1;
                if (m_k == 2) begin
                    if (d.cls == C_BEQ) begin e_pc = 1; e_done = 1; e_bt = alu_zero; fin = 1; end
                end else if (d.cls == C_R || d.cls == C_I) begin
                    e_rw = 1; e_pc = 1; e_done = 1; fin = 1;
                end else if (!m_memdone) begin
                    if (d.cls == C_LW) e_mr = 1; else e_mw = 1;
                    if (mem_ready) begin
                        m_memdone = 1;
                        if (d.cls == C_SW) begin e_pc = 1; e_done = 1; fin = 1; end
                    end
                end else begin
                    e_rw = 1; e_m2r = 1; e_pc = 1; e_done = 1; fin = 1;
                end
            end
            m_k++;
            if (fin) m_busy = 0;
        end
        check("instr_ready",  32'(instr_ready),  32'(e_ready));
        check("alu_op",       32'(alu_op),       32'(e_op));
        check("alu_src_imm",  32'(alu_src_imm),  32'(e_src));
        check("mem_read",     32'(mem_read),     32'(e_mr));
        check("mem_write",    32'(mem_write),    32'(e_mw));
        check("mem_to_reg",   32'(mem_to_reg),   32'(e_m2r));
        check("reg_write",    32'(reg_write),    32'(e_rw));
        check("pc_write",     32'(pc_write),     32'(e_pc));
        check("branch_taken", 32'(branch_taken), 32'(e_bt));
        check("done",         32'(done),         32'(e_done));
        check("illegal",      32'(illegal),      32'(e_ill));
        if (chk_imm) check("imm", imm, e_imm);
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge with the DUT idle; that cycle is cycle 0.
    task automatic run_instr(input string name, input logic [31:0] w, input logic zero,
                             input int mw, input bit hold, input int exp_lat,
                             input bit chk_imm, input logic [31:0] exp_imm);
        int          lat;
        logic [31:0] imm_seen;
        lat = 0;
        imm_seen = 32'd0;
        instr = w; instr_valid = 1'b1; alu_zero = zero; mem_ready = (mw == 0);
        @(posedge clk); #1;
        if (!hold) begin
            instr_valid = 1'b0;
            instr = $urandom;
        end
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (mw != 0) mem_ready = (cyc >= 3 + mw);
            @(negedge clk);
            if (done) begin
                lat = cyc;
                imm_seen = imm;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (chk_imm) check({name, "_imm"}, imm_seen, exp_imm);
        $display("txn %-8s instr=%h zero=%0b memwait=%0d latency=%0d imm=%h",
                 name, w, zero, mw, lat, imm_seen);
    endtask

    initial begin
        rst_n = 1'b1; instr = 32'h002081B3; instr_valid = 1'b1; alu_zero = 1'b0; mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        // Reset held with instr_valid high: idle outputs, nothing accepted.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_done",  32'(done),        32'd0);
        check("rst_imm",   imm,              32'd0);
        check("rst_aluop", 32'(alu_op),      32'd0);
        rst_n = 1'b1; instr_valid = 1'b0;
        @(posedge clk); #1;

        run_instr("add",     32'h002081B3, 1'b0, 0, 1'b0, 3, 1'b0, 32'd0);
        run_instr("sub",     32'h402081B3, 1'b1, 0, 1'b1, 3, 1'b0, 32'd0);
        run_instr("beq_t",   32'h00208463, 1'b1, 0, 1'b0, 2, 1'b1, 32'h00000008);
        run_instr("beq_nt",  32'h00208463, 1'b0, 0, 1'b0, 2, 1'b1, 32'h00000008);
        run_instr("beq_neg", 32'hFE208CE3, 1'b1, 0, 1'b0, 2, 1'b1, 32'hFFFFFFF8);
        run_instr("lw",      32'h0040A283, 1'b0, 2, 1'b0, 6, 1'b1, 32'h00000004);
        run_instr("lw_fast", 32'h0040A283, 1'b1, 0, 1'b0, 4, 1'b1, 32'h00000004);
        run_instr("sw",      32'hFE50AE23, 1'b0, 0, 1'b0, 3, 1'b1, 32'hFFFFFFFC);
        run_instr("sw_wait", 32'hFE50AE23, 1'b0, 1, 1'b1, 4, 1'b1, 32'hFFFFFFFC);
        run_instr("ori",     32'hFFF16093, 1'b0, 0, 1'b0, 3, 1'b1, 32'hFFFFFFFF);
        run_instr("andi",    32'h7F017093, 1'b0, 0, 1'b0, 3, 1'b1, 32'h000007F0);
        run_instr("or",      32'h0020E1B3, 1'b0, 0, 1'b0, 3, 1'b0, 32'd0);
        run_instr("and",     32'h0020F1B3, 1'b1, 0, 1'b0, 3, 1'b0, 32'd0);
        run_instr("ill_0",   32'h00000000, 1'b0, 0, 1'b0, 1, 1'b0, 32'd0);
        run_instr("ill_subor", 32'h4020E1B3, 1'b0, 0, 1'b0, 1, 1'b0, 32'd0);
        run_instr("ill_lb",  32'h00408283, 1'b0, 0, 1'b0, 1, 1'b0, 32'd0);

        // Reset asserted during the MEM phase of lw aborts with no retirement.
        instr = 32'h0040A283; instr_valid = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort_mem_read", 32'(mem_read), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_ready",  32'(instr_ready), 32'd1);
        check("abort_done",   32'(done),        32'd0);
        check("abort_rw",     32'(reg_write),   32'd0);
        check("abort_pcw",    32'(pc_write),    32'd0);
        check("abort_memrd",  32'(mem_read),    32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        $display("txn %-8s instr=%h aborted by reset in MEM", "lw_abort", 32'h0040A283);
        @(posedge clk); #1;
        run_instr("add_post", 32'h002081B3, 1'b0, 0, 1'b0, 3, 1'b0, 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
